// File: rtl/archie_kbd_pkg.sv
// Archimedes keyboard protocol: byte codes, engine states and
// mouse accumulator arithmetic shared by the protocol engine.
package archie_kbd_pkg;

    localparam logic [7:0] HRST = 8'hFF;
    localparam logic [7:0] RAK1 = 8'hFE;
    localparam logic [7:0] RAK2 = 8'hFD;
    localparam logic [7:0] RQID = 8'h20;
    localparam logic [7:0] RQMP = 8'h22;
    localparam logic [7:0] BACK = 8'h3F;
    localparam logic [7:0] NACK = 8'h30;
    localparam logic [7:0] SACK = 8'h31;
    localparam logic [7:0] MACK = 8'h32;
    localparam logic [7:0] SMAK = 8'h33;
    localparam logic [7:0] KDDA = 8'hC0;
    localparam logic [7:0] KUDA = 8'hD0;
    localparam logic [7:0] KBID = 8'h80;

    typedef enum logic [3:0] {
        S_POR,
        S_W_HRST,
        S_W_RAK1,
        S_W_RAK2,
        S_READY,
        S_K_BACK,
        S_K_ACK,
        S_M_BACK,
        S_M_ACK
    } state_e;

    // Mouse bytes carry only 7 signed bits; larger motion is sent in pieces.
    function automatic logic [6:0] clamp7(input logic [9:0] a);
        if ($signed(a) > 10'sd63) return 7'h3F;
        if ($signed(a) < -10'sd64) return 7'h40;
        return a[6:0];
    endfunction

    function automatic logic [9:0] sat_add(input logic [9:0] a,
                                           input logic [7:0] d,
                                           input logic [6:0] s);
        logic signed [10:0] t;
        t = $signed({a[9], a}) + $signed({{3{d[7]}}, d})
            - $signed({{4{s[6]}}, s});
        if (t > 11'sd511) return 10'h1FF;
        if (t < -11'sd512) return 10'h200;
        return t[9:0];
    endfunction

endpackage

// File: rtl/archie_kbd_proto_kbd_fifo.sv
// Key-event FIFO holding {up, row, col} entries; flush empties it
// and takes priority over push and pop.
module kbd_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst_i,
    input  logic       flush,
    input  logic       push,
    input  logic [8:0] push_data,
    input  logic       pop,
    output logic [8:0] pop_data,
    output logic       full,
    output logic       empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_q, wr_d, rd_q, rd_d;
    logic [8:0]  mem_q [DEPTH];
    logic        do_push, do_pop;

    assign empty    = wr_q == rd_q;
    assign full     = (wr_q[AW] != rd_q[AW]) &&
                      (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign pop_data = mem_q[rd_q[AW-1:0]];
    assign do_push  = push && !full && !flush;
    assign do_pop   = pop && !empty && !flush;

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (flush) begin
            wr_d = '0;
            rd_d = '0;
        end else begin
            if (do_push) wr_d = wr_q + (AW+1)'(1);
            if (do_pop)  rd_d = rd_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/archie_kbd_proto.sv
// Archimedes keyboard protocol engine: reset handshake, key and mouse
// transactions with BACK/ack flow control, replies delayed RESP_DELAY.
module archie_kbd_proto
    import archie_kbd_pkg::*;
#(
    parameter int         FIFO_DEPTH = 8,
    parameter logic [5:0] KBD_ID     = 6'h01,
    parameter int         RESP_DELAY = 16
) (
    input  logic       clkcpu,
    input  logic       rst_i,
    input  logic [7:0] host_data,
    input  logic       host_strobe,
    output logic [7:0] kbd_data,
    output logic       kbd_strobe,
    input  logic       key_valid,
    input  logic [7:0] key_code,
    input  logic       key_up,
    output logic       key_ready,
    input  logic       mouse_valid,
    input  logic [7:0] mouse_dx,
    input  logic [7:0] mouse_dy,
    input  logic [2:0] mouse_btn,
    output logic [2:0] leds
);
    localparam int TW = $clog2(RESP_DELAY + 1);

    state_e        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [7:0]    resp_q, resp_d;
    logic [7:0]    kbd_data_q, kbd_data_d;
    logic          kbd_strobe_q, kbd_strobe_d;
    logic          hold_vld_q, hold_vld_d;
    logic [7:0]    hold_q, hold_d;
    logic [1:0]    scan_q, scan_d;
    logic [2:0]    leds_q, leds_d;
    logic [9:0]    accx_q, accx_d, accy_q, accy_d;
    logic [6:0]    sx_q, sx_d, sy_q, sy_d;
    logic [2:0]    btn_q, btn_d;

    logic       busy, byte_vld, is_ack;
    logic       send, flush, pop, latch, sub, mstart;
    logic [7:0] hbyte, send_byte, kpre;
    logic       f_full, f_empty, f_push;
    logic [8:0] f_wdata, f_head;
    logic [2:0] bdiff;
    logic [1:0] bidx;

    kbd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clkcpu),
        .rst_i     (rst_i),
        .flush     (flush),
        .push      (f_push),
        .push_data (f_wdata),
        .pop       (pop),
        .pop_data  (f_head),
        .full      (f_full),
        .empty     (f_empty)
    );

    assign busy       = timer_q != '0;
    assign byte_vld   = !busy && (host_strobe || hold_vld_q);
    assign hbyte      = host_strobe ? host_data : hold_q;
    assign is_ack     = hbyte inside {NACK, SACK, MACK, SMAK};
    assign kpre       = f_head[8] ? KUDA : KDDA;
    assign bdiff      = mouse_btn ^ btn_q;
    assign key_ready  = !f_full && (bdiff == '0);
    assign kbd_data   = kbd_data_q;
    assign kbd_strobe = kbd_strobe_q;
    assign leds       = leds_q;

    always_comb begin
        state_d   = state_q;
        scan_d    = scan_q;
        leds_d    = leds_q;
        send      = 1'b0;
        send_byte = HRST;
        flush     = 1'b0;
        pop       = 1'b0;
        latch     = 1'b0;
        sub       = 1'b0;
        mstart    = 1'b0;
        if (!busy) begin
            if (state_q == S_POR) begin
                send    = 1'b1;
                state_d = S_W_HRST;
            end else if (byte_vld && hbyte == HRST) begin
                send    = 1'b1;
                flush   = 1'b1;
                scan_d  = '0;
                state_d = S_W_RAK1;
            end else begin
                unique case (state_q)
                    S_W_RAK1, S_W_RAK2: if (byte_vld) begin
                        send    = 1'b1;
                        state_d = S_W_HRST;
                        if (state_q == S_W_RAK1 && hbyte == RAK1) begin
                            send_byte = RAK1;
                            state_d   = S_W_RAK2;
                        end else if (state_q == S_W_RAK2 && hbyte == RAK2) begin
                            send_byte = RAK2;
                            state_d   = S_READY;
                        end
                    end
                    S_READY: if (byte_vld) begin
                        if (is_ack) begin
                            scan_d = hbyte[1:0];
                        end else if (hbyte[7:3] == 5'd0) begin
                            leds_d = hbyte[2:0];
                        end else if (hbyte == RQID) begin
                            send      = 1'b1;
                            send_byte = KBID | {2'b00, KBD_ID};
                        end else if (hbyte == RQMP) begin
                            mstart = 1'b1;
                        end
                    end else if (scan_q[0] && !f_empty) begin
                        send      = 1'b1;
                        send_byte = kpre | {4'h0, f_head[7:4]};
                        state_d   = S_K_BACK;
                    end else if (scan_q[1] && (accx_q != '0 || accy_q != '0)) begin
                        mstart = 1'b1;
                    end
                    S_K_BACK, S_M_BACK: if (byte_vld) begin
                        send    = 1'b1;
                        state_d = S_W_HRST;
                        if (hbyte == BACK && state_q == S_K_BACK) begin
                            send_byte = kpre | {4'h0, f_head[3:0]};
                            state_d   = S_K_ACK;
                        end else if (hbyte == BACK) begin
                            send_byte = {1'b0, sy_q};
                            state_d   = S_M_ACK;
                        end
                    end
                    S_K_ACK, S_M_ACK: if (byte_vld) begin
                        if (is_ack) begin
                            scan_d  = hbyte[1:0];
                            pop     = state_q == S_K_ACK;
                            sub     = state_q == S_M_ACK;
                            state_d = S_READY;
                        end else begin
                            send    = 1'b1;
                            state_d = S_W_HRST;
                        end
                    end
                    default: ;
                endcase
                if (mstart) begin
                    send      = 1'b1;
                    send_byte = {1'b0, clamp7(accx_q)};
                    latch     = 1'b1;
                    state_d   = S_M_BACK;
                end
            end
        end
    end

    always_comb begin
        timer_d      = timer_q;
        resp_d       = resp_q;
        kbd_data_d   = kbd_data_q;
        kbd_strobe_d = 1'b0;
        if (busy) begin
            timer_d = timer_q - 1'b1;
            if (timer_q == TW'(1)) begin
                kbd_strobe_d = 1'b1;
                kbd_data_d   = resp_q;
            end
        end else if (send) begin
            timer_d = TW'(RESP_DELAY);
            resp_d  = send_byte;
        end
        hold_vld_d = busy && (hold_vld_q || host_strobe);
        hold_d     = (busy && host_strobe) ? host_data : hold_q;
        sx_d   = latch ? clamp7(accx_q) : sx_q;
        sy_d   = latch ? clamp7(accy_q) : sy_q;
        accx_d = sat_add(accx_q, mouse_valid ? mouse_dx : 8'h00,
                         sub ? sx_q : 7'h00);
        accy_d = sat_add(accy_q, mouse_valid ? mouse_dy : 8'h00,
                         sub ? sy_q : 7'h00);
        if (flush) begin
            accx_d = '0;
            accy_d = '0;
        end
        // Button edges outrank external keys, lowest button first.
        btn_d   = btn_q;
        f_push  = 1'b0;
        f_wdata = {key_up, key_code};
        if (bdiff[0])      bidx = 2'd0;
        else if (bdiff[1]) bidx = 2'd1;
        else               bidx = 2'd2;
        if (bdiff != '0) begin
            if (!f_full && !flush) begin
                f_push       = 1'b1;
                f_wdata      = {~mouse_btn[bidx], 4'h7, 2'b00, bidx};
                btn_d[bidx]  = mouse_btn[bidx];
            end
        end else if (key_valid && key_ready && !flush) begin
            f_push = 1'b1;
        end
    end

    always_ff @(posedge clkcpu) begin
        if (rst_i) begin
            state_q      <= S_POR;
            timer_q      <= '0;
            resp_q       <= '0;
            kbd_data_q   <= '0;
            kbd_strobe_q <= 1'b0;
            hold_vld_q   <= 1'b0;
            hold_q       <= '0;
            scan_q       <= '0;
            leds_q       <= '0;
            accx_q       <= '0;
            accy_q       <= '0;
            sx_q         <= '0;
            sy_q         <= '0;
            btn_q        <= '0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            resp_q       <= resp_d;
            kbd_data_q   <= kbd_data_d;
            kbd_strobe_q <= kbd_strobe_d;
            hold_vld_q   <= hold_vld_d;
            hold_q       <= hold_d;
            scan_q       <= scan_d;
            leds_q       <= leds_d;
            accx_q       <= accx_d;
            accy_q       <= accy_d;
            sx_q         <= sx_d;
            sy_q         <= sy_d;
            btn_q        <= btn_d;
        end
    end

endmodule

// File: tb/tb_archie_kbd_proto.sv
// Bench for archie_kbd_proto: vector table for the host command path,
// directed transactions and randomized key/mouse traffic vs a model.
module tb_archie_kbd_proto;

    localparam int RD = 16;

    logic       clkcpu = 1'b0;
    logic       rst_i = 1'b1;
    logic [7:0] host_data = '0;
    logic       host_strobe = 1'b0;
    logic [7:0] kbd_data;
    logic       kbd_strobe;
    logic       key_valid = 1'b0;
    logic [7:0] key_code = '0;
    logic       key_up = 1'b0;
    logic       key_ready;
    logic       mouse_valid = 1'b0;
    logic [7:0] mouse_dx = '0;
    logic [7:0] mouse_dy = '0;
    logic [2:0] mouse_btn = '0;
    logic [2:0] leds;

    int n_cmp = 0;
    int n_bad = 0;

    archie_kbd_proto dut (
        .clkcpu      (clkcpu),
        .rst_i       (rst_i),
        .host_data   (host_data),
        .host_strobe (host_strobe),
        .kbd_data    (kbd_data),
        .kbd_strobe  (kbd_strobe),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .key_up      (key_up),
        .key_ready   (key_ready),
        .mouse_valid (mouse_valid),
        .mouse_dx    (mouse_dx),
        .mouse_dy    (mouse_dy),
        .mouse_btn   (mouse_btn),
        .leds        (leds)
    );

    always #5 clkcpu = ~clkcpu;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_host(input logic [7:0] b);
        host_data   = b;
        host_strobe = 1'b1;
        @(negedge clkcpu);
        host_strobe = 1'b0;
    endtask

    task automatic get_reply(input string name, output logic [7:0] d,
                             output int lat);
        d   = 8'h00;
        lat = 0;
        while (lat < 200) begin
            @(negedge clkcpu);
            lat++;
            if (kbd_strobe) begin
                d = kbd_data;
                return;
            end
        end
        n_cmp++;
        n_bad++;
        $display("FAIL %s: no reply within 200 cycles", name);
        lat = -1;
    endtask

    task automatic exp_reply(input string name, input logic [7:0] e);
        logic [7:0] d;
        int lat;
        get_reply(name, d, lat);
        if (lat >= 0) chk(name, d, e);
    endtask

    task automatic expect_none(input string name);
        int seen;
        seen = 0;
        repeat (RD + 8) begin
            @(negedge clkcpu);
            if (kbd_strobe) seen++;
        end
        chk(name, seen, 0);
    endtask

    task automatic push_key(input logic [7:0] code, input logic up);
        key_code  = code;
        key_up    = up;
        key_valid = 1'b1;
        @(negedge clkcpu);
        key_valid = 1'b0;
    endtask

    task automatic mouse_in(input int dx, input int dy);
        mouse_dx    = 8'(dx);
        mouse_dy    = 8'(dy);
        mouse_valid = 1'b1;
        @(negedge clkcpu);
        mouse_valid = 1'b0;
    endtask

    task automatic key_txn(input string name, input logic up,
                           input logic [7:0] code, input logic [7:0] ack);
        logic [7:0] pre;
        pre = up ? 8'hD0 : 8'hC0;
        exp_reply({name, "_row"}, pre | {4'h0, code[7:4]});
        send_host(8'h3F);
        exp_reply({name, "_col"}, pre | {4'h0, code[3:0]});
        send_host(ack);
    endtask

    function automatic int clamp(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    function automatic logic [7:0] mbyte(input int acc);
        return 8'(clamp(acc, -64, 63) & 8'h7F);
    endfunction

    typedef struct {
        logic [7:0] host;
        bit         has_reply;
        logic [7:0] reply;
        logic [2:0] leds;
    } vec_t;

    typedef struct {
        logic [7:0] code;
        logic       up;
    } key_t;

    vec_t vt[7];
    key_t kq[$];
    int   ax, ay, sx, sy;

    initial begin
        vt[0] = '{8'hFF, 1'b1, 8'hFF, 3'b000};
        vt[1] = '{8'hFE, 1'b1, 8'hFE, 3'b000};
        vt[2] = '{8'hFD, 1'b1, 8'hFD, 3'b000};
        vt[3] = '{8'h33, 1'b0, 8'h00, 3'b000};
        vt[4] = '{8'h20, 1'b1, 8'h81, 3'b000};
        vt[5] = '{8'h05, 1'b0, 8'h00, 3'b101};
        vt[6] = '{8'h30, 1'b0, 8'h00, 3'b101};

        repeat (3) @(negedge clkcpu);
        chk("rst_strobe", kbd_strobe, 1'b0);
        chk("rst_data", kbd_data, 8'h00);
        chk("rst_leds", leds, 3'b000);
        chk("rst_ready", key_ready, 1'b1);
        rst_i = 1'b0;
        exp_reply("por_hrst", 8'hFF);

        // Handshake and command table
        for (int i = 0; i < 7; i++) begin
            logic [7:0] d;
            int lat;
            send_host(vt[i].host);
            if (vt[i].has_reply) begin
                get_reply($sformatf("vec%0d", i), d, lat);
                if (lat >= 0) begin
                    chk($sformatf("vec%0d_data", i), d, vt[i].reply);
                    chk($sformatf("vec%0d_lat", i), lat, RD);
                end
            end else begin
                expect_none($sformatf("vec%0d_quiet", i));
            end
            chk($sformatf("vec%0d_leds", i), leds, vt[i].leds);
        end

        // Single key press and release
        send_host(8'h31);
        push_key(8'h5A, 1'b0);
        key_txn("k_press", 1'b0, 8'h5A, 8'h31);
        push_key(8'h5A, 1'b1);
        key_txn("k_release", 1'b1, 8'h5A, 8'h31);
        expect_none("k_drained");

        // FIFO full: ninth key dropped, exactly eight transactions
        send_host(8'h30);
        repeat (2) @(negedge clkcpu);
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("ff_ready%0d", i), key_ready, i < 8);
            push_key(8'h10 + 8'(i), 1'b0);
        end
        chk("ff_ready_full", key_ready, 1'b0);
        send_host(8'h31);
        for (int i = 0; i < 8; i++)
            key_txn($sformatf("ff_txn%0d", i), 1'b0, 8'h10 + 8'(i), 8'h31);
        expect_none("ff_ninth_dropped");
        chk("ff_ready_back", key_ready, 1'b1);

        // Mouse saturation then clamp to 7 bits
        send_host(8'h30);
        repeat (6) mouse_in(100, 0);
        send_host(8'h32);
        exp_reply("m_sat_x", 8'h3F);
        send_host(8'h3F);
        exp_reply("m_sat_y", 8'h00);
        send_host(8'h30);
        mouse_in(-128, -1);
        mouse_in(-128, 0);
        mouse_in(-128, 0);
        mouse_in(-127, 0);
        send_host(8'h22);
        exp_reply("m_rem_x", 8'h41);
        send_host(8'h3F);
        exp_reply("m_neg1_y", 8'h7F);
        send_host(8'h30);
        expect_none("m_quiet");

        // Randomized mouse traffic against an arithmetic model
        ax = 0;
        ay = 0;
        for (int r = 0; r < 20; r++) begin
            int dx, dy;
            repeat ($urandom_range(0, 6)) begin
                dx = int'($signed(8'($urandom_range(0, 255))));
                dy = int'($signed(8'($urandom_range(0, 255))));
                mouse_in(dx, dy);
                ax = clamp(ax + dx, -512, 511);
                ay = clamp(ay + dy, -512, 511);
            end
            sx = clamp(ax, -64, 63);
            sy = clamp(ay, -64, 63);
            send_host(8'h22);
            exp_reply($sformatf("rm%0d_x", r), mbyte(ax));
            dx = int'($signed(8'($urandom_range(0, 255))));
            mouse_in(dx, 0);
            ax = clamp(ax + dx, -512, 511);
            send_host(8'h3F);
            exp_reply($sformatf("rm%0d_y", r), 8'(sy & 8'h7F));
            dy = int'($signed(8'($urandom_range(0, 255))));
            mouse_in(0, dy);
            ay = clamp(ay + dy, -512, 511);
            send_host(8'h30);
            ax = clamp(ax - sx, -512, 511);
            ay = clamp(ay - sy, -512, 511);
        end

        // Randomized key bursts with a queue model
        for (int r = 0; r < 4; r++) begin
            int n;
            n = $urandom_range(1, 11);
            kq.delete();
            for (int i = 0; i < n; i++) begin
                key_t k;
                k.code = 8'($urandom_range(0, 255));
                k.up   = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 1) == 1) @(negedge clkcpu);
                chk($sformatf("rk%0d_ready%0d", r, i), key_ready, kq.size() < 8);
                push_key(k.code, k.up);
                if (kq.size() < 8) kq.push_back(k);
            end
            send_host(8'h31);
            while (kq.size() > 0) begin
                key_t k;
                k = kq.pop_front();
                key_txn($sformatf("rk%0d", r), k.up, k.code,
                        kq.size() == 0 ? 8'h30 : 8'h31);
            end
            expect_none($sformatf("rk%0d_quiet", r));
        end

        // Two button presses in one cycle
        mouse_btn = 3'b101;
        #1;
        chk("btn_ready_low", key_ready, 1'b0);
        @(negedge clkcpu);
        repeat (3) @(negedge clkcpu);
        chk("btn_ready_back", key_ready, 1'b1);
        send_host(8'h31);
        key_txn("btn_l", 1'b0, 8'h70, 8'h31);
        key_txn("btn_r", 1'b0, 8'h72, 8'h30);
        expect_none("btn_quiet");

        // HRST mid-transaction flushes and restarts the handshake
        send_host(8'h31);
        push_key(8'h5A, 1'b0);
        exp_reply("rec_row", 8'hC5);
        push_key(8'h11, 1'b0);
        send_host(8'hFF);
        exp_reply("rec_hrst", 8'hFF);
        send_host(8'h3F);
        exp_reply("rec_bad_rak1", 8'hFF);
        send_host(8'hFF);
        exp_reply("rec_hs1", 8'hFF);
        send_host(8'hFE);
        exp_reply("rec_hs2", 8'hFE);
        send_host(8'hFD);
        exp_reply("rec_hs3", 8'hFD);
        send_host(8'h31);
        expect_none("rec_flushed");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
